// File: rtl/ram_1r1w_fifo_ctrl_if.sv
// Valid/ready stream bundle for ram_1r1w_fifo_ctrl.
//   in_data/in_valid/in_ready    : write side (producer -> FIFO)
//   out_data/out_valid/out_ready : read side (FIFO -> consumer)
// master: the producer/consumer environment; slave: the FIFO controller.
interface ram_1r1w_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ram_1r1w_fifo_ctrl.sv
// FIFO controller that keeps its entries in an external 1R1W RAM and
// prefetches them into a 2-entry output buffer.
//   clk, rst     : clock, synchronous active-high reset
//   fifo         : stream bundle (slave side): in_* write side, out_* read side
//   level        : entries held (RAM + output buffer + read in flight)
//   ram_wr_*     : RAM write command (data, addr, enable, mask)
//   ram_rd_*     : RAM read command (addr, enable, mask); ram_rd_data returns
//                  one cycle after ram_rd_en
module ram_1r1w_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
  parameter int unsigned NUM_PARTITIONS = 1,
  parameter int unsigned LEVEL_WIDTH    = $clog2(DEPTH + 3)
) (
  input  logic                      clk,
  input  logic                      rst,
  ram_1r1w_fifo_ctrl_if.slave       fifo,
  output logic [LEVEL_WIDTH-1:0]    level,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic [ADDR_WIDTH-1:0]     ram_wr_addr,
  output logic                      ram_wr_en,
  output logic [NUM_PARTITIONS-1:0] ram_wr_mask,
  output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
  output logic                      ram_rd_en,
  output logic [NUM_PARTITIONS-1:0] ram_rd_mask,
  input  logic [DATA_WIDTH-1:0]     ram_rd_data
);

  localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  op_e                   last_op_q, last_op_d;

  logic [PTR_WIDTH-1:0]  ram_cnt;
  logic [1:0]            ob_keep;
  logic                  rd_want;
  logic                  in_ready;
  logic                  out_valid;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  pop;

  // State register; data slots are not reset (out_data is don't-care while empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ob_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      last_op_q <= OP_READ;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ob0_q     <= ob0_d;
      ob1_q     <= ob1_d;
      ob_cnt_q  <= ob_cnt_d;
      rd_pend_q <= rd_pend_d;
      last_op_q <= last_op_d;
    end
  end

  // Arbitration between RAM write and prefetch read, plus output buffer update.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ob0_d     = ob0_q;
    ob1_d     = ob1_q;
    ob_cnt_d  = ob_cnt_q;
    rd_pend_d = 1'b0;
    last_op_d = last_op_q;

    ram_cnt = wr_ptr_q - rd_ptr_q;
    // Prefetch only while the buffer plus the in-flight read leave a free slot.
    rd_want = (ram_cnt != '0) && ((ob_cnt_q + 2'(rd_pend_q)) <= 2'd1);
    // A write yields to a wanted read only if the previous RAM op was a write.
    in_ready  = !rst && (ram_cnt != PTR_WIDTH'(DEPTH)) &&
                (!rd_want || (last_op_q == OP_READ));
    wr_fire   = fifo.in_valid && in_ready;
    rd_fire   = rd_want && !wr_fire && !rst;
    out_valid = (ob_cnt_q != 2'd0) && !rst;
    pop       = out_valid && fifo.out_ready;
    ob_keep   = ob_cnt_q - 2'(pop);

    if (wr_fire) begin
      wr_ptr_d  = wr_ptr_q + PTR_WIDTH'(1);
      last_op_d = OP_WRITE;
    end
    if (rd_fire) begin
      rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(1);
      rd_pend_d = 1'b1;
      last_op_d = OP_READ;
    end

    if (pop) begin
      ob0_d = ob1_q;
    end
    // Returning read data lands behind whatever survives this cycle's pop.
    if (rd_pend_q) begin
      if (ob_keep == 2'd0) begin
        ob0_d = ram_rd_data;
      end else begin
        ob1_d = ram_rd_data;
      end
    end
    ob_cnt_d = ob_keep + 2'(rd_pend_q);
  end

  assign fifo.in_ready  = in_ready;
  assign fifo.out_valid = out_valid;
  assign fifo.out_data  = ob0_q;

  assign level = rst ? '0 :
                 LEVEL_WIDTH'(ram_cnt) + LEVEL_WIDTH'(ob_cnt_q) + LEVEL_WIDTH'(rd_pend_q);

  assign ram_wr_data = fifo.in_data;
  assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_wr_en   = wr_fire;
  assign ram_wr_mask = '1;
  assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign ram_rd_en   = rd_fire;
  assign ram_rd_mask = '1;

endmodule

// File: tb/tb_ram_1r1w_fifo_ctrl.sv
// Bench for ram_1r1w_fifo_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ram_1r1w_fifo_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = 5;

  logic          clk;
  logic          rst;
  logic [LW-1:0] level;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_wr_en;
  logic [0:0]    ram_wr_mask;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rd_en;
  logic [0:0]    ram_rd_mask;
  logic [DW-1:0] ram_rd_data;

  ram_1r1w_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ram_1r1w_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo       (bus),
    .level      (level),
    .ram_wr_data(ram_wr_data),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_mask(ram_wr_mask),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_mask(ram_rd_mask),
    .ram_rd_data(ram_rd_data)
  );

  // Behavioural RAM: a write issued together with a read is dropped.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en && !ram_rd_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: entries in RAM, read in flight, output buffer, push order.
  logic [DW-1:0] m_ram_q[$];
  logic [DW-1:0] m_ob_q[$];
  logic [DW-1:0] sb_q[$];
  bit            m_pend;
  logic [DW-1:0] m_pend_data;
  bit            m_last_read;
  int            m_wr_idx, m_rd_idx;
  int            pushes, pops;
  int            wr_wraps, rd_wraps;
  logic [AW-1:0] prev_wa, prev_ra;

  initial begin
    m_pend = 0; m_last_read = 1; m_wr_idx = 0; m_rd_idx = 0;
    pushes = 0; pops = 0; wr_wraps = 0; rd_wraps = 0; prev_wa = '0; prev_ra = '0;
  end

  always @(negedge clk) begin
    int  ram_cnt, occ, e_level;
    bit  rd_want, e_in_ready, e_wr, e_rd, e_ov, e_pop;
    chk("mask_wr", 64'(ram_wr_mask), 64'(1));
    chk("mask_rd", 64'(ram_rd_mask), 64'(1));
    chk("ops_exclusive", 64'(ram_wr_en && ram_rd_en), 64'(0));
    if (rst) begin
      chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_level", 64'(level), 64'(0));
      chk("rst_wr_en", 64'(ram_wr_en), 64'(0));
      chk("rst_rd_en", 64'(ram_rd_en), 64'(0));
      m_ram_q.delete(); m_ob_q.delete(); sb_q.delete();
      m_pend = 0; m_last_read = 1; m_wr_idx = 0; m_rd_idx = 0;
      pushes = 0; pops = 0; prev_wa = '0; prev_ra = '0;
    end else begin
      ram_cnt    = m_ram_q.size();
      occ        = m_ob_q.size() + int'(m_pend);
      e_level    = ram_cnt + occ;
      rd_want    = (ram_cnt != 0) && (occ <= 1);
      e_in_ready = (ram_cnt != DEPTH) && (!rd_want || m_last_read);
      e_wr       = bus.in_valid && e_in_ready;
      e_rd       = rd_want && !e_wr;
      e_ov       = m_ob_q.size() != 0;
      e_pop      = e_ov && bus.out_ready;
      chk("in_ready", 64'(bus.in_ready), 64'(e_in_ready));
      chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
      chk("level", 64'(level), 64'(e_level));
      chk("level_vs_traffic", 64'(level), 64'(pushes - pops));
      chk("ram_wr_en", 64'(ram_wr_en), 64'(e_wr));
      chk("ram_rd_en", 64'(ram_rd_en), 64'(e_rd));
      if (e_wr) begin
        chk("ram_wr_addr", 64'(ram_wr_addr), 64'(m_wr_idx % DEPTH));
        chk("ram_wr_data", 64'(ram_wr_data), 64'(bus.in_data));
      end
      if (e_rd) chk("ram_rd_addr", 64'(ram_rd_addr), 64'(m_rd_idx % DEPTH));
      if (e_ov) chk("out_data", 64'(bus.out_data), 64'(m_ob_q[0]));
      if (e_pop) begin
        chk("order", 64'(bus.out_data), (sb_q.size() != 0) ? 64'(sb_q[0]) : 64'hDEAD);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        pops++;
      end
      if (ram_wr_en) begin
        if (prev_wa == AW'(DEPTH - 1) && ram_wr_addr == '0) wr_wraps++;
        prev_wa = ram_wr_addr;
      end
      if (ram_rd_en) begin
        if (prev_ra == AW'(DEPTH - 1) && ram_rd_addr == '0) rd_wraps++;
        prev_ra = ram_rd_addr;
      end
      // Advance the model across the coming clock edge.
      if (e_pop) void'(m_ob_q.pop_front());
      if (m_pend) m_ob_q.push_back(m_pend_data);
      m_pend = 0;
      if (e_rd) begin
        m_pend = 1;
        m_pend_data = m_ram_q.pop_front();
        m_rd_idx++;
        m_last_read = 1;
      end
      if (e_wr) begin
        m_ram_q.push_back(bus.in_data);
        sb_q.push_back(bus.in_data);
        m_wr_idx++;
        m_last_read = 0;
        pushes++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Push n consecutive values starting at base, holding data until accepted.
  task automatic push_n(input int n, input int base);
    int  i = 0;
    int  t = 0;
    bit  acc;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(base);
    while (i < n && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      t++;
      if (acc) begin
        i++;
        bus.in_data = DW'(base + i);
      end
    end
    bus.in_valid = 1'b0;
    chk("push_count", 64'(i), 64'(n));
  endtask

  task automatic rand_phase(input int cycles, input int pv, input int pr);
    bit acc = 1;
    for (int c = 0; c < cycles; c++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(99) < pv);
        bus.in_data  = $urandom;
      end
      bus.out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got[$];
    int nw, nr, both, d, t;
    bit acc;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    // 1: single entry latency and level sequence
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data = 32'hA5A5_0001;
    @(negedge clk);
    chk("t1_wr_en_c0", 64'(ram_wr_en), 64'(1));
    chk("t1_wr_addr_c0", 64'(ram_wr_addr), 64'(0));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_rd_en_c1", 64'(ram_rd_en), 64'(1));
    chk("t1_level_c1", 64'(level), 64'(1));
    step();
    @(negedge clk);
    chk("t1_out_valid_c2", 64'(bus.out_valid), 64'(0));
    chk("t1_level_c2", 64'(level), 64'(1));
    step();
    @(negedge clk);
    chk("t1_out_valid_c3", 64'(bus.out_valid), 64'(1));
    chk("t1_out_data_c3", 64'(bus.out_data), 64'h0000_0000_A5A5_0001);
    chk("t1_level_c3", 64'(level), 64'(1));
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_level_c4", 64'(level), 64'(1));
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t1_level_after_pop", 64'(level), 64'(0));
    chk("t1_out_valid_after_pop", 64'(bus.out_valid), 64'(0));

    // 2: fill to DEPTH+2, then drain in order
    do_reset();
    push_n(DEPTH + 2, 0);
    repeat (3) step();
    @(negedge clk);
    chk("t2_full_level", 64'(level), 64'(DEPTH + 2));
    chk("t2_full_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    bus.out_ready = 1'b1;
    got.delete();
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (bus.out_valid) got.push_back(bus.out_data);
      if (level == '0) break;
      step();
      t++;
    end
    chk("t2_drain_count", 64'(got.size()), 64'(DEPTH + 2));
    chk("t2_first", (got.size() != 0) ? 64'(got[0]) : 64'hBAD, 64'(0));
    chk("t2_last", (got.size() != 0) ? 64'(got[got.size()-1]) : 64'hBAD, 64'(DEPTH + 1));
    chk("t2_empty_out_valid", 64'(bus.out_valid), 64'(0));
    bus.out_ready = 1'b0;

    // 3: continuous traffic, writes and reads alternate
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    d = 1000;
    bus.in_data = DW'(d);
    nw = 0; nr = 0; both = 0;
    repeat (200) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (ram_wr_en) nw++;
      if (ram_rd_en) nr++;
      if (ram_wr_en && ram_rd_en) both++;
      step();
      if (acc) begin
        d++;
        bus.in_data = DW'(d);
      end
    end
    bus.in_valid = 1'b0;
    chk("t3_both_ops", 64'(both), 64'(0));
    chk("t3_writes_steady", 64'(nw >= 95), 64'(1));
    chk("t3_reads_steady", 64'(nr >= 95), 64'(1));

    // 4: pointer wrap across three fill/drain rounds
    do_reset();
    wr_wraps = 0;
    rd_wraps = 0;
    d = 5000;
    for (int r = 0; r < 3; r++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = DW'(d);
      t = 0;
      while (t < 100) begin
        @(negedge clk);
        if (level == LW'(DEPTH + 2)) break;
        acc = bus.in_ready;
        step();
        t++;
        if (acc) begin
          d++;
          bus.in_data = DW'(d);
        end
      end
      bus.in_valid = 1'b0;
      chk("t4_full_level", 64'(level), 64'(DEPTH + 2));
      chk("t4_full_in_ready", 64'(bus.in_ready), 64'(0));
      step();
      t = 0;
      while (t < 400) begin
        bus.out_ready = 1'($urandom_range(1));
        @(negedge clk);
        if (level == '0) break;
        step();
        t++;
      end
      chk("t4_empty_level", 64'(level), 64'(0));
      chk("t4_empty_out_valid", 64'(bus.out_valid), 64'(0));
      step();
    end
    bus.out_ready = 1'b0;
    chk("t4_wr_wraps", 64'(wr_wraps), 64'(3));
    chk("t4_rd_wraps", 64'(rd_wraps), 64'(3));

    // 5: reset with a read in flight and five entries held
    do_reset();
    push_n(6, 32'h100);
    repeat (3) step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_pop_ready", 64'(bus.out_valid), 64'(1));
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t5_rd_en", 64'(ram_rd_en), 64'(1));
    chk("t5_level_pre", 64'(level), 64'(5));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_level_post", 64'(level), 64'(0));
    chk("t5_out_valid_post", 64'(bus.out_valid), 64'(0));
    step();
    bus.in_valid = 1'b1;
    bus.in_data = 32'h1234;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    t = 0;
    while (t < 10) begin
      @(negedge clk);
      if (bus.out_valid) break;
      step();
      t++;
    end
    chk("t5_new_valid", 64'(bus.out_valid), 64'(1));
    chk("t5_new_data", 64'(bus.out_data), 64'h1234);
    step();
    nw = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) nw++;
      step();
    end
    chk("t5_no_stale", 64'(nw), 64'(0));
    bus.out_ready = 1'b0;

    // 6: random traffic at both duty mixes
    do_reset();
    rand_phase(5000, 30, 70);
    rand_phase(5000, 70, 30);
    @(negedge clk);
    chk("t6_pushes_seen", 64'(pushes > 1000), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
